// File: rtl/game_io_ctrl.sv
// KCPSM6 port decode, registered read-back mux and maskable multi-source IRQ.
// Define GAME_IO_BTN_IRQ_EN to build the button-press interrupt source (pend[1]).
module game_io_ctrl #(
    parameter int TICK_PERIOD = 50_000_000,
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_BTNS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              port_id,
    input  logic [7:0]              out_port,
    output logic [7:0]              in_port,
    input  logic                    write_strobe,
    input  logic                    k_write_strobe,
    input  logic                    read_strobe,
    output logic                    interrupt,
    input  logic                    interrupt_ack,
    input  logic [NUM_BTNS-1:0]     db_btns,
    input  logic [7:0]              db_sw,
    input  logic [1:0]              randomized_value,
    input  logic                    game_status,
    output logic [7:0]              led,
    output logic [5*NUM_DIGITS-1:0] dig,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              game_info
);

    localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

    logic [7:0]          r_led;
    logic [4:0]          r_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_dp;
    logic [7:0]          r_gi;
    logic [7:0]          r_mask;
    logic [2:0]          r_pend;
    logic [CW-1:0]       r_tick;
    logic                r_gs_prev;
    logic [7:0]          r_in_port;
    logic                r_irq;

    logic                w_tick;
    logic                w_gs_edge;
    logic                w_btn_edge;
    logic [2:0]          w_set;
    logic [2:0]          w_clr;
    logic [2:0]          w_pend_next;
    logic                w_irq_next;
    logic [7:0]          w_rd;
    logic                w_unused;

    // Constant-write and read strobes carry no behaviour here.
    assign w_unused = k_write_strobe ^ read_strobe;

    assign w_tick    = (r_tick == CW'(TICK_PERIOD - 1));
    assign w_gs_edge = game_status & ~r_gs_prev;

`ifdef GAME_IO_BTN_IRQ_EN
    logic [NUM_BTNS-1:0] r_btn_prev;

    assign w_btn_edge = |(db_btns & ~r_btn_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_prev <= '0;
        end else begin
            r_btn_prev <= db_btns;
        end
    end
`else
    assign w_btn_edge = 1'b0;
`endif

    assign w_set = {w_gs_edge, w_btn_edge, w_tick};
    assign w_clr = (write_strobe && port_id == 8'h0B) ? out_port[2:0] : 3'b000;

    // A source firing on the same edge as its W1C keeps the bit set.
    assign w_pend_next = (r_pend & ~w_clr) | w_set;
    assign w_irq_next  = (|(w_pend_next & r_mask[2:0])) & ~interrupt_ack;

    always_comb begin
        w_rd = 8'h00;
        case (port_id)
            8'h00:   w_rd = 8'(db_btns);
            8'h01:   w_rd = db_sw;
            8'h02:   w_rd = {7'b0, game_status};
            8'h0A:   w_rd = r_mask;
            8'h0B:   w_rd = {5'b0, r_pend};
            8'h0F:   w_rd = {6'b0, randomized_value};
            default: w_rd = 8'h00;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (port_id == 8'(16 + i)) begin
                w_rd = {3'b000, r_dig[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= 8'h00;
            r_dp      <= '0;
            r_gi      <= 8'h00;
            r_mask    <= 8'h01;
            r_pend    <= 3'b000;
            r_tick    <= '0;
            r_gs_prev <= 1'b0;
            r_in_port <= 8'h00;
            r_irq     <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_dig[i] <= 5'd0;
            end
        end else begin
            r_tick    <= w_tick ? '0 : r_tick + CW'(1);
            r_gs_prev <= game_status;
            r_pend    <= w_pend_next;
            r_irq     <= w_irq_next;
            r_in_port <= w_rd;
            if (write_strobe) begin
                case (port_id)
                    8'h02:   r_led  <= out_port;
                    8'h07:   r_dp   <= out_port[NUM_DIGITS-1:0];
                    8'h09:   r_gi   <= out_port;
                    8'h0A:   r_mask <= out_port;
                    default: ;
                endcase
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (write_strobe && port_id == 8'(16 + i)) begin
                    r_dig[i] <= out_port[4:0];
                end
            end
        end
    end

    always_comb begin
        dig = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig[5*i +: 5] = r_dig[i];
        end
    end

    assign led       = r_led;
    assign dp        = r_dp;
    assign game_info = r_gi;
    assign in_port   = r_in_port;
    assign interrupt = r_irq;

endmodule

// File: tb/tb_game_io_ctrl.sv
// Scoreboard bench for game_io_ctrl: a cycle-level reference model pushes
// expected outputs; a monitor pops and compares them after each clock edge.
module tb_game_io_ctrl;

    localparam int P  = 10;
    localparam int ND = 4;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      port_id = 8'h00;
    logic [7:0]      out_port = 8'h00;
    logic [7:0]      in_port;
    logic            write_strobe = 1'b0;
    logic            k_write_strobe = 1'b0;
    logic            read_strobe = 1'b0;
    logic            interrupt;
    logic            interrupt_ack = 1'b0;
    logic [NB-1:0]   db_btns = '0;
    logic [7:0]      db_sw = 8'h00;
    logic [1:0]      randomized_value = 2'b00;
    logic            game_status = 1'b0;
    logic [7:0]      led;
    logic [5*ND-1:0] dig;
    logic [ND-1:0]   dp;
    logic [7:0]      game_info;

    game_io_ctrl #(
        .TICK_PERIOD(P),
        .NUM_DIGITS (ND),
        .NUM_BTNS   (NB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .port_id         (port_id),
        .out_port        (out_port),
        .in_port         (in_port),
        .write_strobe    (write_strobe),
        .k_write_strobe  (k_write_strobe),
        .read_strobe     (read_strobe),
        .interrupt       (interrupt),
        .interrupt_ack   (interrupt_ack),
        .db_btns         (db_btns),
        .db_sw           (db_sw),
        .randomized_value(randomized_value),
        .game_status     (game_status),
        .led             (led),
        .dig             (dig),
        .dp              (dp),
        .game_info       (game_info)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      in_port;
        logic            irq;
        logic [7:0]      led;
        logic [5*ND-1:0] dig;
        logic [ND-1:0]   dp;
        logic [7:0]      gi;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Next-cycle values for the slow inputs, applied by cyc().
    logic          n_rst = 1'b1;
    logic          n_gs = 1'b0;
    logic [NB-1:0] n_btns = '0;

    // Reference model state.
    logic [7:0]    m_led = 8'h00;
    logic [7:0]    m_gi = 8'h00;
    logic [7:0]    m_mask = 8'h01;
    logic [ND-1:0] m_dp = '0;
    logic [4:0]    m_dig [ND];
    logic [2:0]    m_pend = 3'b000;
    int            m_cyc = 0;
    logic          m_gs_prev = 1'b0;
    logic [NB-1:0] m_btn_prev = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        exp_t       e;
        logic [7:0] rd;
        logic [2:0] set;
        logic [2:0] clr;
        logic [2:0] pn;
        int         a;
        a  = int'(port_id);
        rd = 8'h00;
        if (a == 0)       rd = 8'(db_btns);
        else if (a == 1)  rd = db_sw;
        else if (a == 2)  rd = {7'b0, game_status};
        else if (a == 10) rd = m_mask;
        else if (a == 11) rd = {5'b0, m_pend};
        else if (a == 15) rd = {6'b0, randomized_value};
        else if (a >= 16 && a < 16 + ND) rd = {3'b0, m_dig[a-16]};
        if (rst) begin
            m_led = 8'h00; m_gi = 8'h00; m_mask = 8'h01; m_dp = '0;
            m_pend = 3'b000; m_cyc = 0; m_gs_prev = 1'b0; m_btn_prev = '0;
            for (int i = 0; i < ND; i++) m_dig[i] = 5'd0;
            e.in_port = 8'h00;
            e.irq = 1'b0;
        end else begin
            set[0] = ((m_cyc % P) == P - 1);
`ifdef GAME_IO_BTN_IRQ_EN
            set[1] = |(db_btns & ~m_btn_prev);
`else
            set[1] = 1'b0;
`endif
            set[2] = game_status && !m_gs_prev;
            clr = (write_strobe && a == 11) ? out_port[2:0] : 3'b000;
            pn = (m_pend & ~clr) | set;
            e.irq = (|(pn & m_mask[2:0])) && !interrupt_ack;
            e.in_port = rd;
            m_pend = pn;
            m_cyc++;
            m_gs_prev = game_status;
            m_btn_prev = db_btns;
            if (write_strobe) begin
                if (a == 2)  m_led = out_port;
                if (a == 7)  m_dp = out_port[ND-1:0];
                if (a == 9)  m_gi = out_port;
                if (a == 10) m_mask = out_port;
                if (a >= 16 && a < 16 + ND) m_dig[a-16] = out_port[4:0];
            end
        end
        e.led = m_led;
        e.dp  = m_dp;
        e.gi  = m_gi;
        for (int i = 0; i < ND; i++) e.dig[5*i +: 5] = m_dig[i];
        q.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] pid, input logic [7:0] d,
                       input logic ws, input logic ack);
        @(negedge clk);
        rst = n_rst;
        game_status = n_gs;
        db_btns = n_btns;
        port_id = pid;
        out_port = d;
        write_strobe = ws;
        interrupt_ack = ack;
        k_write_strobe = 1'($urandom);
        read_strobe = 1'($urandom);
        db_sw = 8'($urandom);
        randomized_value = 2'($urandom);
        model_step();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("in_port", 32'(in_port), 32'(e.in_port));
                chk("interrupt", 32'(interrupt), 32'(e.irq));
                chk("led", 32'(led), 32'(e.led));
                chk("dig", 32'(dig), 32'(e.dig));
                chk("dp", 32'(dp), 32'(e.dp));
                chk("game_info", 32'(game_info), 32'(e.gi));
            end
        end
    end

    initial begin
        logic [7:0] addrs [16];
        logic [7:0] pid;
        logic [7:0] d;
        addrs = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0B,
                  8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20, 8'hFF};

        // Reset and read-back of reset values
        n_rst = 1'b1;
        cyc(8'h0A, 8'h00, 1'b0, 1'b0);
        cyc(8'h0A, 8'h00, 1'b0, 1'b0);
        n_rst = 1'b0;
        cyc(8'h0A, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h02, 8'h00, 1'b0, 1'b0);
        cyc(8'h10, 8'h00, 1'b0, 1'b0);

        // Writes, including an unmapped address
        cyc(8'h02, 8'h5A, 1'b1, 1'b0);
        cyc(8'h11, 8'h13, 1'b1, 1'b0);
        cyc(8'h20, 8'hFF, 1'b1, 1'b0);
        cyc(8'h11, 8'h00, 1'b0, 1'b0);
        cyc(8'h11, 8'h00, 1'b0, 1'b0);

        // Periodic tick, ack, re-assert, W1C
        n_rst = 1'b1;
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        n_rst = 1'b0;
        for (int i = 0; i < 11; i++) cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(8'h0B, 8'h00, 1'b0, 1'b0);

        // W1C on the very edge the tick fires
        for (int k = 0; k < 2 * P && (m_cyc % P) != P - 1; k++)
            cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h01, 1'b1, 1'b0);
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);

        // game_status edge with mask 0x04, then 0x00
        cyc(8'h0A, 8'h04, 1'b1, 1'b0);
        cyc(8'h0B, 8'hFF, 1'b1, 1'b0);
        n_gs = 1'b1;
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        n_gs = 1'b0;
        cyc(8'h0A, 8'h00, 1'b1, 1'b0);
        cyc(8'h0B, 8'hFF, 1'b1, 1'b0);
        n_gs = 1'b1;
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        n_gs = 1'b0;

        // Button press edge with mask 0x02
        cyc(8'h0A, 8'h02, 1'b1, 1'b0);
        cyc(8'h0B, 8'hFF, 1'b1, 1'b0);
        n_btns = 4'b0100;
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h0B, 8'h00, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 1'b0, 1'b0);
        n_btns = 4'b0000;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            n_rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) n_gs = ~n_gs;
            if ($urandom_range(0, 5) == 0) n_btns = NB'($urandom);
            pid = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                              : addrs[$urandom_range(0, 15)];
            d = 8'($urandom);
            cyc(pid, d, 1'($urandom), $urandom_range(0, 5) == 0);
        end
        n_rst = 1'b0;
        cyc(8'h0A, 8'h00, 1'b0, 1'b0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_io_ctrl.md
# game_io_ctrl

Parametrised KCPSM6 I/O port controller for the game datapath: decodes PicoBlaze port writes into LED, seven-segment digit, decimal-point and game-info registers. It muxes board inputs onto `in_port` with registered read-back. It replaces the single fixed-period interrupt with a prioritised-free, maskable, multi-source interrupt controller: periodic tick, game-status rising edge, and button press. It sits between `kcpsm6`, the debouncer and `sevensegment`.

## Interface
Parameters:
- `TICK_PERIOD`, 50_000_000, clocks per periodic tick; ≥2.
- `NUM_DIGITS`, 4, number of seven-segment digits; 1..8.
- `NUM_BTNS`, 4, debounced button count; 1..8.

Ports:
- `clk` in 1 system clock.
- `rst` in 1 reset. One clock; reset is synchronous and active-high.
- `port_id` in 8 KCPSM6 port address.
- `out_port` in 8 KCPSM6 write data.
- `in_port` out 8 KCPSM6 read data, registered.
- `write_strobe` in 1 write qualifier.
- `k_write_strobe` in 1 constant-write strobe; ignored.
- `read_strobe` in 1 read qualifier; used only for side-effect-free reads (no action).
- `interrupt` out 1 to KCPSM6.
- `interrupt_ack` in 1 from KCPSM6.
- `db_btns` in NUM_BTNS debounced buttons.
- `db_sw` in 8 debounced switches.
- `randomized_value` in 2 LFSR output.
- `game_status` in 1 game-over flag.
- `led` out 8 LED register.
- `dig` out 5*NUM_DIGITS digit codes; digit i at `[5*i+4:5*i]`.
- `dp` out NUM_DIGITS decimal points.
- `game_info` out 8 game-info register.

## Operation
- Write decode (only when `write_strobe`=1): 0x02→`led`, 0x07→`dp` (low NUM_DIGITS bits), 0x09→`game_info`, 0x0A→IRQ_MASK, 0x0B→IRQ_PEND write-1-to-clear, 0x10+i (i<NUM_DIGITS)→digit i (low 5 bits). All other addresses are ignored; no register changes.
- Read mux (every cycle, independent of `read_strobe`):
  - 0x00: `db_btns` zero-extended.
  - 0x01: `db_sw`.
  - 0x02: {7'b0,`game_status`}.
  - 0x0A: IRQ_MASK.
  - 0x0B: IRQ_PEND.
  - 0x0F: {6'b0,`randomized_value`}.
  - 0x10+i: {3'b0,digit i}.
  - Any other address: 0x00.
- IRQ_PEND bits:
  - [0]: tick.
  - [1]: button rising edge (any button 0→1).
  - [2]: `game_status` rising edge.
  - [7:3]: read 0.
- Tick counter runs 0..TICK_PERIOD-1 and wraps. At count == TICK_PERIOD-1 it sets pend[0]. Counter width is $clog2(TICK_PERIOD).
- Edge detectors register previous `db_btns`/`game_status`. Edge = cur & ~prev.
- Set beats clear: if a source fires in the same cycle as a W1C write to its bit, the bit stays 1.
- IRQ_MASK bits [7:3] are stored but have no effect.
- `interrupt` next = |(IRQ_PEND_next & IRQ_MASK[2:0]) & ~`interrupt_ack`. After acknowledge, it re-asserts the cycle after ack if an enabled bit is still pending. The ISR clears IRQ_PEND before RETURNI.

## Timing
- Reset values:
  - `led`, `dig`, `dp`, `game_info`, `in_port`, IRQ_PEND, tick count and edge-history registers: 0.
  - IRQ_MASK: 0x01.
  - `interrupt`: 0.
- Write latency: the register updates on the clock edge where `write_strobe`=1. The new value is visible the next cycle.
- Read latency: `in_port` is valid 1 cycle after `port_id` is stable. This fits the KCPSM6 2-cycle INPUT window.
- Source event at edge N → IRQ_PEND bit set at N+1 → `interrupt` high at N+1 if masked in.
- `rst` asserted mid-count or mid-interrupt: everything returns to reset values on that edge, and no pending event survives.
- `interrupt_ack` has priority over any new assertion in the same cycle.

## Configuration
- `GAME_IO_BTN_IRQ_EN` defined: the button-edge source (pend[1]) is built as described.
- Undefined: there is no button edge logic. pend[1] is tied 0, so reading 0x0B always shows bit1=0. Mask bit1 is stored but has no effect, and `db_btns` is still readable at 0x00.

## Test plan
- Reset, then read all addresses: 0x0A→0x01, 0x0B/0x02/0x10→0x00; `interrupt`=0 and all outputs 0.
- Write 0x5A to 0x02, 0x13 to 0x11, 0xFF to 0x20 → `led`=0x5A, `dig[9:5]`=0x13, all other outputs unchanged; reading 0x11 gives 0x13.
- TICK_PERIOD=10: `interrupt` rises 10 cycles after reset and drops on `interrupt_ack`. It re-asserts the next cycle until 0x01 is written to 0x0B, then it stays low until the next tick, 10 cycles after the previous one.
- Mask=0x04, `game_status` 0→1 → pend=0x04, `interrupt`=1. With mask=0x00, the same edge gives pend=0x04 and `interrupt`=0.
- W1C 0x01 to 0x0B in the same cycle the tick fires → pend[0] remains 1.
- Macro defined, mask=0x02, `db_btns` 0000→0100 → pend[1]=1, `interrupt`=1. Macro undefined → pend stays 0x00.
